// File: rtl/sb_rx_deframer_if.sv
// Sideband receive deframer output bundle.
// Payload strobes, markers and error pulses.
interface sb_rx_deframer_if;
  logic [7:0] trans_byte;
  logic       trans_valid;
  logic       trans_sop;
  logic       trans_eop;
  logic       trans_type;
  logic [6:0] trans_len;
  logic       frame_err;
  logic       stuff_err;
  logic       len_err;

  modport master (
    output trans_byte, trans_valid,
    output trans_sop, trans_eop,
    output trans_type, trans_len,
    output frame_err, stuff_err, len_err
  );

  modport slave (
    input trans_byte, trans_valid,
    input trans_sop, trans_eop,
    input trans_type, trans_len,
    input frame_err, stuff_err, len_err
  );
endinterface

// File: rtl/sb_rx_deframer.sv
// Sideband 8N1 receiver with DLE/STX..DLE/ETX
// deframing, DLE unstuffing and one-byte hold.
module sb_rx_deframer #(
  parameter int         MAX_LEN = 64,
  parameter logic [7:0] DLE     = 8'hFE,
  parameter logic [7:0] STX_CMD = 8'h05,
  parameter logic [7:0] STX_RSP = 8'h04,
  parameter logic [7:0] ETX     = 8'h40
) (
  input  logic             sb_clk,
  input  logic             rst,
  input  logic             sbrx,
  sb_rx_deframer_if.master trans
);
  localparam logic [6:0] MAXC = 7'(MAX_LEN);

  typedef enum logic [1:0] {
    B_IDLE, B_DATA, B_STOP, B_BREAK
  } bstate_t;

  typedef enum logic [1:0] {
    F_HUNT, F_STX, F_PAY, F_ESC
  } fstate_t;

  bstate_t    b_q, b_d;
  logic [2:0] bit_q;
  logic [7:0] shr_q;
  logic       byte_rdy;
  logic       stop_bad;

  fstate_t    f_q, f_d;
  logic       is_pay, is_end, is_start;
  logic       is_stuff, is_abort, is_stx;
  logic       ovf;

  logic [6:0] cnt_q, cnt_d;
  logic [7:0] hold_q, hold_d;
  logic       full_q, full_d;
  logic       type_q, type_d;

  logic [7:0] byte_q, byte_d;
  logic       valid_q, valid_d;
  logic       sop_q, sop_d;
  logic       eop_q, eop_d;
  logic [6:0] len_q, len_d;
  logic       ferr_q, ferr_d;
  logic       serr_q, serr_d;
  logic       lerr_q, lerr_d;

  // bit FSM state, bit counter and LSB-first shifter
  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      b_q   <= B_IDLE;
      bit_q <= '0;
      shr_q <= '0;
    end else begin
      b_q <= b_d;
      if (b_q == B_IDLE) begin
        bit_q <= '0;
      end else if (b_q == B_DATA) begin
        bit_q <= bit_q + 3'd1;
        shr_q <= {sbrx, shr_q[7:1]};
      end
    end
  end

  // bit FSM next state
  always_comb begin
    b_d = b_q;
    unique case (b_q)
      B_IDLE:  if (!sbrx) b_d = B_DATA;
      B_DATA:  if (bit_q == 3'd7) b_d = B_STOP;
      B_STOP:  b_d = sbrx ? B_IDLE : B_BREAK;
      B_BREAK: if (sbrx) b_d = B_IDLE;
      default: b_d = B_IDLE;
    endcase
  end

  // bit FSM outputs: good byte or broken stop bit
  always_comb begin
    byte_rdy = (b_q == B_STOP) && sbrx;
    stop_bad = (b_q == B_STOP) && !sbrx;
  end

  // frame FSM state, holding register and outputs
  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      f_q     <= F_HUNT;
      cnt_q   <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      type_q  <= 1'b0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      len_q   <= '0;
      ferr_q  <= 1'b0;
      serr_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      f_q     <= f_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      type_q  <= type_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      len_q   <= len_d;
      ferr_q  <= ferr_d;
      serr_q  <= serr_d;
      lerr_q  <= lerr_d;
    end
  end

  // frame FSM next state and byte classification
  always_comb begin
    f_d      = f_q;
    is_pay   = 1'b0;
    is_end   = 1'b0;
    is_start = 1'b0;
    is_stuff = 1'b0;
    is_abort = 1'b0;
    is_stx   = (shr_q == STX_CMD) ||
               (shr_q == STX_RSP);
    ovf      = 1'b0;
    if (stop_bad) begin
      f_d      = F_HUNT;
      is_abort = 1'b1;
    end else if (byte_rdy) begin
      unique case (f_q)
        F_HUNT: begin
          if (shr_q == DLE) f_d = F_STX;
        end
        F_STX: begin
          if (is_stx) begin
            f_d      = F_PAY;
            is_start = 1'b1;
          end else begin
            f_d = F_HUNT;
          end
        end
        F_PAY: begin
          if (shr_q == DLE) f_d = F_ESC;
          else is_pay = 1'b1;
        end
        default: begin
          unique case (1'b1)
            shr_q == DLE: begin
              f_d    = F_PAY;
              is_pay = 1'b1;
            end
            shr_q == ETX: begin
              f_d    = F_HUNT;
              is_end = 1'b1;
            end
            is_stx: begin
              f_d      = F_PAY;
              is_stuff = 1'b1;
              is_start = 1'b1;
            end
            default: begin
              f_d      = F_HUNT;
              is_stuff = 1'b1;
              is_abort = 1'b1;
            end
          endcase
        end
      endcase
      if (is_pay && cnt_q == MAXC) begin
        f_d = F_HUNT;
        ovf = 1'b1;
      end
    end
  end

  // hold-one pipeline: emit held byte on next payload or ETX
  always_comb begin
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    full_d  = full_q;
    type_d  = type_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    len_d   = '0;
    ferr_d  = stop_bad;
    serr_d  = is_stuff;
    lerr_d  = 1'b0;
    if (is_abort) full_d = 1'b0;
    if (is_start) begin
      cnt_d  = '0;
      full_d = 1'b0;
      type_d = (shr_q == STX_RSP);
    end
    if (is_pay) begin
      if (ovf) begin
        lerr_d = 1'b1;
        full_d = 1'b0;
        cnt_d  = MAXC + 7'd1;
      end else begin
        if (full_q) begin
          valid_d = 1'b1;
          sop_d   = (cnt_q == 7'd1);
          byte_d  = hold_q;
        end
        hold_d = shr_q;
        full_d = 1'b1;
        cnt_d  = cnt_q + 7'd1;
      end
    end
    if (is_end) begin
      if (full_q) begin
        valid_d = 1'b1;
        eop_d   = 1'b1;
        sop_d   = (cnt_q == 7'd1);
        byte_d  = hold_q;
        len_d   = cnt_q;
      end else begin
        lerr_d = 1'b1;
      end
      full_d = 1'b0;
    end
  end

  assign trans.trans_byte  = byte_q;
  assign trans.trans_valid = valid_q;
  assign trans.trans_sop   = sop_q;
  assign trans.trans_eop   = eop_q;
  assign trans.trans_type  = type_q;
  assign trans.trans_len   = len_q;
  assign trans.frame_err   = ferr_q;
  assign trans.stuff_err   = serr_q;
  assign trans.len_err     = lerr_q;
endmodule
